// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request/ready handshake, IF/ID register and a
// one-entry skid buffer that catches a word returned while the decoder is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic [31:0] PcPlus4,
    output logic        instr_valid
);

    typedef enum logic [0:0] {StReq, StHeld} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [31:0] skid_q;
    logic [31:0] skid_pc4_q;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            skid_q     <= 32'd0;
            skid_pc4_q <= 32'd0;
        end else if (branch_taken) begin
            // Redirect wins over stall and drops any word returned this cycle.
            state_q <= StReq;
            pc_q    <= {branch_target[31:2], 2'b00};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem_ready) begin
                        pc_q <= pc_plus4;
                        if (stall) begin
                            skid_q     <= imem_rdata;
                            skid_pc4_q <= pc_plus4;
                            state_q    <= StHeld;
                        end else begin
                            instr_q <= imem_rdata;
                            pc4_q   <= pc_plus4;
                            valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                    end
                end
                StHeld: begin
                    if (!stall) begin
                        instr_q <= skid_q;
                        pc4_q   <= skid_pc4_q;
                        valid_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    // No request while the skid is occupied, so at most one word is ever in flight.
    assign imem_req    = (state_q == StReq) && !reset;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PcPlus4     = pc4_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each vector's expected outputs go into a queue that a
// negedge monitor drains and compares against the DUT.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instr;
    logic [31:0] PcPlus4;
    logic        instr_valid;

    localparam logic [31:0] Bad = 32'hBAD0_0000;

    typedef struct {
        string       name;
        bit          chk;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .Instr        (Instr),
        .PcPlus4      (PcPlus4),
        .instr_valid  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs seen during the cycle in which the vector's inputs are applied.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                n_vec++;
                if (imem_req !== e.req || imem_addr !== e.addr || Instr !== e.instr ||
                    PcPlus4 !== e.pc4 || instr_valid !== e.valid) begin
                    n_bad++;
                    $display("FAIL %s: got req=%b addr=%h instr=%h pc4=%h valid=%b, want req=%b addr=%h instr=%h pc4=%h valid=%b",
                             e.name, imem_req, imem_addr, Instr, PcPlus4, instr_valid,
                             e.req, e.addr, e.instr, e.pc4, e.valid);
                end
            end
        end
    end

    task automatic vec(input string nm, input logic rst, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata,
                       input bit chk, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = rdata;
        e.name  = nm;
        e.chk   = chk;
        e.req   = e_req;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pc4   = e_pc4;
        e.valid = e_valid;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;

        //  name          rst  stl  br   tgt            rdy  rdata          chk req addr           instr          pc4            v
        vec("rst0",       1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         0, 1'b0,32'h0,         32'h0,         32'h0,         1'b0);
        vec("rst1",       1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         1, 1'b0,32'h0,         32'h0,         32'h0,         1'b0);
        // Zero-wait stream from address 0.
        vec("stream0",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h8C01_0004, 1, 1'b1,32'h0,         32'h0,         32'h0,         1'b0);
        vec("stream4",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'hAC01_0008, 1, 1'b1,32'h4,         32'h8C01_0004, 32'h4,         1'b1);
        vec("stream8",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h2001_0001, 1, 1'b1,32'h8,         32'hAC01_0008, 32'h8,         1'b1);
        vec("streamC",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h2002_0002, 1, 1'b1,32'hC,         32'h2001_0001, 32'hC,         1'b1);
        // Three wait states at 0x10.
        vec("wait1",      1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h10,        32'h2002_0002, 32'h10,        1'b1);
        vec("wait2",      1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h10,        32'h2002_0002, 32'h10,        1'b0);
        vec("wait3",      1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h10,        32'h2002_0002, 32'h10,        1'b0);
        vec("waitdone",   1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1234_5678, 1, 1'b1,32'h10,        32'h2002_0002, 32'h10,        1'b0);
        vec("fetch14",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h3C01_0014, 1, 1'b1,32'h14,        32'h1234_5678, 32'h14,        1'b1);
        vec("fetch18",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h3C02_0018, 1, 1'b1,32'h18,        32'h3C01_0014, 32'h18,        1'b1);
        vec("fetch1C",    1'b0,1'b0,1'b0,32'h0,         1'b1,32'h3C03_001C, 1, 1'b1,32'h1C,        32'h3C02_0018, 32'h1C,        1'b1);
        // Stall for two cycles while the word at 0x20 returns.
        vec("stall_acc",  1'b0,1'b1,1'b0,32'h0,         1'b1,32'hDEAD_0020, 1, 1'b1,32'h20,        32'h3C03_001C, 32'h20,        1'b1);
        vec("held1",      1'b0,1'b1,1'b0,32'h0,         1'b1,Bad,           1, 1'b0,32'h24,        32'h3C03_001C, 32'h20,        1'b1);
        vec("held_rel",   1'b0,1'b0,1'b0,32'h0,         1'b1,Bad,           1, 1'b0,32'h24,        32'h3C03_001C, 32'h20,        1'b1);
        vec("skid_out",   1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1111_0024, 1, 1'b1,32'h24,        32'hDEAD_0020, 32'h24,        1'b1);
        // Fill the skid, then redirect to 0x103 while stalled.
        vec("skid_fill",  1'b0,1'b1,1'b0,32'h0,         1'b1,32'h2222_0028, 1, 1'b1,32'h28,        32'h1111_0024, 32'h28,        1'b1);
        vec("branch",     1'b0,1'b1,1'b1,32'h103,       1'b1,Bad,           1, 1'b0,32'h2C,        32'h1111_0024, 32'h28,        1'b1);
        vec("br_target",  1'b0,1'b0,1'b0,32'h0,         1'b1,32'h5555_0100, 1, 1'b1,32'h100,       32'h0,         32'h28,        1'b0);
        vec("br_after",   1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h104,       32'h5555_0100, 32'h104,       1'b1);
        // Redirect to the top word and wrap PC+4 to zero.
        vec("br_top",     1'b0,1'b0,1'b1,32'hFFFF_FFFF, 1'b1,Bad,           1, 1'b1,32'h104,       32'h5555_0100, 32'h104,       1'b0);
        vec("wrap_fetch", 1'b0,1'b0,1'b0,32'h0,         1'b1,32'h7777_FFFC, 1, 1'b1,32'hFFFF_FFFC, 32'h0,         32'h104,       1'b0);
        vec("wrap_stall", 1'b0,1'b1,1'b0,32'h0,         1'b1,32'h8888_0000, 1, 1'b1,32'h0,         32'h7777_FFFC, 32'h0,         1'b1);
        // Reset while in the held state with a full skid.
        vec("rst_held",   1'b1,1'b1,1'b0,32'h0,         1'b1,Bad,           1, 1'b0,32'h4,         32'h7777_FFFC, 32'h0,         1'b1);
        vec("rst_hold",   1'b1,1'b0,1'b0,32'h0,         1'b1,Bad,           1, 1'b0,32'h0,         32'h0,         32'h0,         1'b0);
        vec("rst_rel",    1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h0,         32'h0,         32'h0,         1'b0);
        vec("post_rst",   1'b0,1'b0,1'b0,32'h0,         1'b1,32'h8C01_0004, 1, 1'b1,32'h0,         32'h0,         32'h0,         1'b0);
        vec("post_rst2",  1'b0,1'b0,1'b0,32'h0,         1'b0,Bad,           1, 1'b1,32'h4,         32'h8C01_0004, 32'h4,         1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS datapath, directly upstream of the opcode decoder.
- Holds the PC and drives the instruction-memory request/ready handshake.
- Registers the fetched word into an IF/ID register; its Instr output feeds the decoder's 32-bit instruction input (opcode in Instr[31:26]).
- Supports pipeline stall, branch redirect/flush, and a one-entry skid buffer so no fetched word is lost while the decoder is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, word placed in Instr on reset and on flush.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  downstream hazard: hold IF/ID and PC
- branch_taken  input  1  one-cycle redirect pulse from EX (taken beq)
- branch_target  input  32  redirect address
- imem_req  output  1  instruction-memory request
- imem_addr  output  32  request address (= PC)
- imem_rdata  input  32  returned instruction, valid when imem_ready=1
- imem_ready  input  1  memory accepts request and returns data this cycle
- Instr  output  32  IF/ID instruction to decoder
- PcPlus4  output  32  IF/ID PC+4 of Instr
- instr_valid  output  1  Instr holds a real fetched instruction

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state is updated on the rising edge of clk.
- Reset values: pc=RESET_PC, Instr=NOP_INSTR, PcPlus4=0, instr_valid=0, skid empty, state=S_REQ.
- imem_req is 0 while reset=1.
- imem_addr=pc at all times. pc[1:0] is always 00; branch_target[1:0] is ignored (forced to 00).
- PC increment is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- State S_REQ: imem_req=1.
  - imem_ready=1 and stall=0: Instr<=imem_rdata, PcPlus4<=pc+4, instr_valid<=1, pc<=pc+4. Stay in S_REQ.
  - imem_ready=1 and stall=1: skid<=imem_rdata, skid_pc4<=pc+4, pc<=pc+4. IF/ID holds. Go to S_HELD.
  - imem_ready=0 and stall=0: instr_valid<=0 (bubble); Instr/PcPlus4 keep their old values.
  - imem_ready=0 and stall=1: IF/ID holds.
- State S_HELD: imem_req=0. IF/ID holds while stall=1.
  - On stall=0: Instr<=skid, PcPlus4<=skid_pc4, instr_valid<=1. Go to S_REQ.
- branch_taken=1 has highest priority, in any state and regardless of stall:
  - pc<=branch_target&~3, Instr<=NOP_INSTR, instr_valid<=0, skid discarded, state<=S_REQ.
  - Any imem_rdata returned in the same cycle is dropped.
  - The first request to the target is issued the following cycle.
- Memory contract: imem_addr is held stable while imem_req=1 and imem_ready=0, except when a redirect changes it. Memory tolerates that abort.
- Latency: an instruction accepted in cycle N appears on Instr in cycle N+1. Throughput is 1 instruction/cycle with zero-wait memory and no stall.
- reset asserted mid-operation (any state, pending skid, pending request) returns everything to reset values on the next edge.
- No combinational path from stall or branch_taken to imem_req. imem_req depends only on state and reset.

Test Plan:
- Reset then stream: RESET_PC=0, imem_ready=1, memory returns 32'h8C01_0004 (lw) at address 0 and 32'hAC01_0008 (sw) at address 4 → Instr=8C010004/PcPlus4=4 in cycle 1, then AC010008/8 in cycle 2, instr_valid=1, imem_addr=0,4,8.
- Wait states: imem_ready low for 3 cycles at addr 0x10 → instr_valid=0 for those cycles, imem_addr held at 0x10, then the word appears with PcPlus4=0x14.
- Stall with skid: stall=1 for 2 cycles while the word at 0x20 is returned → IF/ID unchanged, imem_req=0 in S_HELD, and on release Instr=word@0x20, PcPlus4=0x24, next imem_addr=0x24, no word lost or duplicated.
- Branch flush: branch_taken=1, branch_target=0x103 while stall=1 and the skid is full → next cycle Instr=NOP_INSTR, instr_valid=0, imem_addr=0x100, skid contents never emitted.
- Wrap and reset mid-op: pc=32'hFFFF_FFFC fetch → PcPlus4=0, next imem_addr=0; then assert reset while in S_HELD → pc=RESET_PC, instr_valid=0, imem_req=0 during reset and 1 the cycle after release.
